// File: rtl/scu_index_sequencer.sv
// scu_index_sequencer: walks every (out_idx, in_idx) channel pair of one layer on a valid/ready stream.
// Optional stall counter output enabled by defining SCU_INDEX_SEQUENCER_STALL_CNT_EN.
module scu_index_sequencer #(
    parameter int IDX_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [IDX_WIDTH-1:0] cfg_out_ch,
    input  logic [IDX_WIDTH-1:0] cfg_in_ch,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [IDX_WIDTH-1:0] m_out_idx,
    output logic [IDX_WIDTH-1:0] m_in_idx,
    output logic [IDX_WIDTH-1:0] m_out_ch,
    output logic [IDX_WIDTH-1:0] m_in_ch,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
`ifdef SCU_INDEX_SEQUENCER_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [IDX_WIDTH-1:0] ONE = IDX_WIDTH'(1);

    logic [1:0]           state;
    logic                 hs;
    logic                 in_wrap;
    logic                 nxt_last;
    logic [IDX_WIDTH-1:0] nxt_out;
    logic [IDX_WIDTH-1:0] nxt_in;

    assign hs       = m_valid & m_ready;
    assign in_wrap  = m_in_idx == m_in_ch - ONE;
    assign nxt_in   = in_wrap ? '0 : m_in_idx + ONE;
    assign nxt_out  = in_wrap ? m_out_idx + ONE : m_out_idx;
    // m_last is registered one beat ahead so the decode never glitches
    assign nxt_last = (nxt_out == m_out_ch - ONE) && (nxt_in == m_in_ch - ONE);
    assign m_valid  = state == RUN;
    assign busy     = state != IDLE;
    assign done     = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_out_idx <= '0;
            m_in_idx  <= '0;
            m_out_ch  <= '0;
            m_in_ch   <= '0;
            m_last    <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                m_out_ch <= cfg_out_ch;
                m_in_ch  <= cfg_in_ch;
                m_last   <= (cfg_out_ch == ONE) && (cfg_in_ch == ONE);
                state    <= (cfg_out_ch != '0 && cfg_in_ch != '0) ? RUN : DONE;
            end
        end else if (state == RUN) begin
            // abort takes priority over a coincident handshake
            if (abort || (hs && m_last)) begin
                state     <= abort ? IDLE : DONE;
                m_out_idx <= '0;
                m_in_idx  <= '0;
                m_last    <= 1'b0;
            end else if (hs) begin
                m_out_idx <= nxt_out;
                m_in_idx  <= nxt_in;
                m_last    <= nxt_last;
            end
        end else begin
            state <= IDLE;
        end
    end

`ifdef SCU_INDEX_SEQUENCER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (m_valid && !m_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
